// File: rtl/spectrum_bar_builder.sv
// Snapshots 16 FFT bins per frame and turns each into a log-scaled bar height,
// with optional peak-hold decay; bars are read back combinationally by index.
module spectrum_bar_builder #(
  parameter int BIN_W       = 24,
  parameter int HEIGHT_STEP = 16,
  parameter int MAX_HEIGHT  = 400,
  parameter int DECAY       = 8
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 frame_completed,
  input  logic [16*BIN_W-1:0]  bins_in,
  input  logic                 decay_en,
  input  logic [3:0]           bar_sel,
  output logic [9:0]           bar_height,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 overrun
);

  typedef enum logic [1:0] {IDLE, PROCESS, DONE} state_t;

  state_t                    state_q, state_d;
  logic [3:0]                idx_q, idx_d;
  logic [15:0][BIN_W-1:0]    snap_q, snap_d;
  logic [15:0][9:0]          bar_q, bar_d;
  logic                      s2_vld_q, s2_vld_d;
  logic [3:0]                s2_idx_q, s2_idx_d;
  logic [9:0]                s2_h_q, s2_h_d;
  logic                      busy_q, busy_d;
  logic                      frame_done_q, frame_done_d;
  logic                      overrun_q, overrun_d;

  logic [BIN_W-1:0]          bin, mag;
  logic [9:0]                h;
  logic [9:0]                old_bar, dec_bar, wr_bar;
  int                        lead;
  int                        h_full;

  // Stage 1: magnitude (most-negative value saturates) -> leading-one height
  always_comb begin
    bin = snap_q[idx_q];
    mag = bin;
    if (bin[BIN_W-1]) begin
      if (bin == {1'b1, {(BIN_W-1){1'b0}}})
        mag = {1'b0, {(BIN_W-1){1'b1}}};
      else
        mag = ~bin + 1'b1;
    end
    lead = 0;
    for (int i = 0; i < BIN_W; i++)
      if (mag[i]) lead = i;
    h_full = (lead + 1) * HEIGHT_STEP;
    if (h_full > MAX_HEIGHT) h_full = MAX_HEIGHT;
    h = (mag == '0) ? 10'd0 : 10'(h_full);
  end

  // Stage 2: peak-hold keeps the larger of the new height and the decayed bar
  always_comb begin
    old_bar = bar_q[s2_idx_q];
    dec_bar = (old_bar >= 10'(DECAY)) ? old_bar - 10'(DECAY) : 10'd0;
    wr_bar  = s2_h_q;
    if (decay_en && dec_bar > s2_h_q) wr_bar = dec_bar;
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    snap_d       = snap_q;
    bar_d        = bar_q;
    s2_vld_d     = 1'b0;
    s2_idx_d     = s2_idx_q;
    s2_h_d       = s2_h_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q;

    if (s2_vld_q) bar_d[s2_idx_q] = wr_bar;

    case (state_q)
      IDLE: begin
        if (frame_completed) begin
          snap_d  = bins_in;
          idx_d   = 4'd0;
          busy_d  = 1'b1;
          state_d = PROCESS;
        end
      end
      PROCESS: begin
        s2_vld_d = 1'b1;
        s2_idx_d = idx_q;
        s2_h_d   = h;
        idx_d    = idx_q + 4'd1;
        if (idx_q == 4'd15) state_d = DONE;
        if (frame_completed) overrun_d = 1'b1;
      end
      DONE: begin
        // bar 15 lands on this edge, so the frame is complete after it
        busy_d       = 1'b0;
        frame_done_d = 1'b1;
        state_d      = IDLE;
        if (frame_completed) overrun_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      snap_q       <= '0;
      bar_q        <= '0;
      s2_vld_q     <= 1'b0;
      s2_idx_q     <= '0;
      s2_h_q       <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      snap_q       <= snap_d;
      bar_q        <= bar_d;
      s2_vld_q     <= s2_vld_d;
      s2_idx_q     <= s2_idx_d;
      s2_h_q       <= s2_h_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bar_height = bar_q[bar_sel];
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_spectrum_bar_builder.sv
// Scoreboard bench: a bar model pushes expected heights per frame, popped on frame_done.
module tb_spectrum_bar_builder;
  localparam int BIN_W = 24;

  logic                Clk = 1'b0;
  logic                Reset_n = 1'b0;
  logic                frame_completed = 1'b0;
  logic [16*BIN_W-1:0] bins_in = '0;
  logic                decay_en = 1'b0;
  logic [3:0]          bar_sel = '0;
  logic [9:0]          bar_height;
  logic                busy, frame_done, overrun;

  spectrum_bar_builder dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_completed(frame_completed),
    .bins_in(bins_in), .decay_en(decay_en), .bar_sel(bar_sel),
    .bar_height(bar_height), .busy(busy), .frame_done(frame_done),
    .overrun(overrun)
  );

  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_pass = 0;
  int model[16];
  int exp_q[$];

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int h_of(input logic [BIN_W-1:0] b);
    longint v;
    int n;
    v = longint'($signed(b));
    if (v < 0) v = -v;
    if (v > 64'd8388607) v = 8388607;
    n = 0;
    while (v > 0) begin n++; v = v >> 1; end
    n = n * 16;
    return (n > 400) ? 400 : n;
  endfunction

  task automatic model_frame(input logic [16*BIN_W-1:0] b, input bit dec);
    int h, d;
    for (int i = 0; i < 16; i++) begin
      h = h_of(b[i*BIN_W +: BIN_W]);
      if (dec) begin
        d = model[i] - 8;
        if (d < 0) d = 0;
        model[i] = (h > d) ? h : d;
      end else model[i] = h;
      exp_q.push_back(model[i]);
    end
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 16; i++) begin
      @(negedge Clk);
      bar_sel = 4'(i);
      #1;
      if (exp_q.size() == 0) check({tag, "_empty_q"}, 1, 0);
      else check($sformatf("%s_bar%0d", tag, i), int'(bar_height), exp_q.pop_front());
    end
  endtask

  // Drives one frame; optionally injects a second pulse at edge N+inj.
  task automatic send(input logic [16*BIN_W-1:0] b, input bit dec, input bit now,
                      input int inj, input logic [16*BIN_W-1:0] alt);
    int done_cyc;
    if (!now) @(negedge Clk);
    bins_in = b;
    decay_en = dec;
    frame_completed = 1'b1;
    model_frame(b, dec);
    @(posedge Clk);
    #1 frame_completed = 1'b0;
    check("busy_rise", int'(busy), 1);
    done_cyc = 0;
    for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
      if (c == inj) begin frame_completed = 1'b1; bins_in = alt; end
      @(posedge Clk);
      #1 frame_completed = 1'b0;
      if (frame_done) done_cyc = c;
    end
    check("done_latency", done_cyc, 17);
    check("busy_fall", int'(busy), 0);
  endtask

  function automatic logic [16*BIN_W-1:0] mk(input int i0, input logic [BIN_W-1:0] v0,
                                             input int i1, input logic [BIN_W-1:0] v1,
                                             input int i2, input logic [BIN_W-1:0] v2);
    logic [16*BIN_W-1:0] r;
    r = '0;
    if (i0 >= 0) r[i0*BIN_W +: BIN_W] = v0;
    if (i1 >= 0) r[i1*BIN_W +: BIN_W] = v1;
    if (i2 >= 0) r[i2*BIN_W +: BIN_W] = v2;
    return r;
  endfunction

  logic [16*BIN_W-1:0] basic, zero, big3, one5, alt;
  int fd_cnt;

  initial begin
    for (int i = 0; i < 16; i++) model[i] = 0;
    basic = mk(3, 24'h000100, 7, 24'hFFFF00, 15, 24'h800000);
    zero  = '0;
    big3  = mk(3, 24'h7FFFFF, -1, '0, -1, '0);
    one5  = mk(5, 24'h000001, -1, '0, -1, '0);
    alt   = mk(0, 24'h7FFFFF, 3, 24'h000001, 9, 24'h001000);

    // reset
    repeat (2) @(posedge Clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(frame_done), 0);
    check("rst_ovr", int'(overrun), 0);
    @(negedge Clk) Reset_n = 1'b1;
    repeat (16) exp_q.push_back(0);
    sweep("rst");

    // basic frame, no decay
    send(basic, 1'b0, 1'b0, 0, '0);
    @(posedge Clk); #1 check("done_once", int'(frame_done), 0);
    sweep("basic");

    // decay of held peaks, then a new larger peak
    send(zero, 1'b1, 1'b0, 0, '0); sweep("decay1");
    send(zero, 1'b1, 1'b0, 0, '0); sweep("decay2");
    send(big3, 1'b1, 1'b0, 0, '0); sweep("decay3");

    // decay floor
    send(one5, 1'b1, 1'b0, 0, '0); sweep("floor0");
    for (int k = 0; k < 3; k++) begin
      send(zero, 1'b1, 1'b0, 0, '0);
      sweep($sformatf("floor%0d", k + 1));
    end

    // overrun: second pulse at edge N+5 is dropped
    check("ovr_pre", int'(overrun), 0);
    send(basic, 1'b0, 1'b0, 5, alt);
    check("ovr_set", int'(overrun), 1);
    @(posedge Clk); #1 check("ovr_done_once", int'(frame_done), 0);
    sweep("ovr");

    // pulse in the frame_done cycle is accepted
    send(alt, 1'b0, 1'b0, 0, '0);
    repeat (16) void'(exp_q.pop_front());
    send(basic, 1'b0, 1'b1, 0, '0);
    sweep("b2b");
    check("ovr_sticky", int'(overrun), 1);

    // reset mid-frame aborts processing
    @(negedge Clk);
    bins_in = big3; decay_en = 1'b0; frame_completed = 1'b1;
    @(posedge Clk); #1 frame_completed = 1'b0;
    repeat (8) @(posedge Clk);
    @(negedge Clk) Reset_n = 1'b0;
    @(posedge Clk); #1;
    check("mrst_busy", int'(busy), 0);
    check("mrst_done", int'(frame_done), 0);
    check("mrst_ovr", int'(overrun), 0);
    @(negedge Clk) Reset_n = 1'b1;
    fd_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge Clk); #1;
      if (frame_done) fd_cnt++;
    end
    check("mrst_no_done", fd_cnt, 0);
    for (int i = 0; i < 16; i++) model[i] = 0;
    repeat (16) exp_q.push_back(0);
    sweep("mrst");
    send(big3, 1'b0, 1'b0, 0, '0);
    sweep("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/spectrum_bar_builder.md
Name: spectrum_bar_builder

Overview:
Sits directly downstream of the FastFourierTransform block and upstream of color_mapper. On each FFT frame_completed pulse it snapshots the 16 signed 24-bit bin outputs and converts each to a log-scaled bar height. It applies optional peak-hold with linear decay, then holds 16 bar heights that color_mapper reads through a combinational select port. It is a multi-cycle sequential stage with a 2-stage per-bin pipeline.

Parameters:
BIN_W, 24, width of each signed FFT bin
HEIGHT_STEP, 16, pixels per octave (per leading-one position)
MAX_HEIGHT, 400, saturation cap on bar height in pixels
DECAY, 8, pixels subtracted per frame from held bar when decay enabled

Ports:
Clk  in  1  system clock (MAX10_CLK1_50)
Reset_n  in  1  synchronous, active-low reset
frame_completed  in  1  one-cycle pulse from FFT: bins valid
bins_in  in  16*BIN_W  packed bins; bin i at [i*BIN_W +: BIN_W], two's complement
decay_en  in  1  1 = peak-hold with decay, 0 = bar follows new value
bar_sel  in  4  bar index requested by color_mapper
bar_height  out  10  height of bar[bar_sel], combinational from registers
busy  out  1  high while a frame is processed
frame_done  out  1  one-cycle pulse after bar 15 is written
overrun  out  1  sticky: frame_completed arrived while busy

Behaviour:
- Reset (Reset_n=0 at a rising edge): state=IDLE, all 16 bars=0, snapshot=0, busy=0, frame_done=0, overrun=0, pipeline valid=0. Applies mid-frame too: processing aborts and no frame_done is issued.
- States: IDLE, PROCESS, DONE.
- IDLE: at an edge with frame_completed=1, latch bins_in into the snapshot, idx<=0, busy<=1, go to PROCESS.
- PROCESS: stage 1 issues bin idx on each edge, idx 0..15 over 16 edges.
  - mag = |bin|. -2^(BIN_W-1) saturates to 2^(BIN_W-1)-1.
  - p = position of the leading one of mag.
  - h = 0 if mag=0, else min((p+1)*HEIGHT_STEP, MAX_HEIGHT). Register mag-derived h and idx.
- Stage 2 writes on the following edge:
  - decay_en=0: bar[idx] <= h.
  - decay_en=1: bar[idx] <= max(h, bar[idx] sat-minus DECAY), floored at 0.
  - decay_en is sampled per bin at stage 2.
- After the stage-1 edge for idx 15, go to DONE. The stage-2 write of bar 15 occurs on the DONE-entry edge +1.
- Timing: frame_completed sampled at edge N. Bar i is written at edge N+2+i. Bar 15 is written at edge N+17. frame_done=1 and busy=0 in the cycle following edge N+17; state returns to IDLE at the same time.
- IDLE accepts a new frame_completed in the same cycle frame_done is high.
- frame_completed while busy=1 (PROCESS/DONE): ignored, overrun<=1. The snapshot is not disturbed. overrun clears only on reset.
- Snapshot register isolates the block from FFT output changes during processing.
- bar_height = bar[bar_sel], with no latency. A read of a bar on its write edge returns the old value before the edge and the new value after it.
- Widths: bars are 10-bit unsigned. With defaults the max height is 24*16=384 < MAX_HEIGHT; the cap must still be implemented.

Test Plan:
- Reset: hold Reset_n=0 for 2 edges -> bar_height=0 for all bar_sel 0..15; busy=0, frame_done=0, overrun=0.
- Basic frame, decay_en=0: x3=24'h000100, x7=24'hFFFF00, x15=24'h800000, others 0; pulse frame_completed at edge N.
  - Expect busy=1 from N+1.
  - Expect frame_done exactly once, in the cycle after N+17.
  - Expect bars 3 and 7 = 144, bar 15 = 368, all others 0.
- Decay, decay_en=1: after the basic frame, send 2 all-zero frames -> bars 3/7 = 136 then 128, bar 15 = 360 then 352. A third frame with x3=24'h7FFFFF -> bar 3 = 368.
- Decay floor, decay_en=1: frame with x5=24'h000001 -> bar5=16. Then three zero frames -> bar5 = 8, 0, 0.
- Overrun: pulse frame_completed at edge N+5 of a busy frame with different bins.
  - Expect overrun=1 and still exactly one frame_done.
  - Expect bars to equal the first frame only.
  - A pulse in the frame_done cycle is accepted, and busy rises next cycle.
- Reset mid-frame: assert Reset_n=0 at edge N+9 -> next cycle all bars 0, busy 0, no frame_done. A new frame after release processes normally.
